kfib_src: RTL
=============

Name: kfib_src

Overview:
- Clocked, parametrised k-order Fibonacci source. It drives a bundled-data req/ack output link in two-phase or four-phase encoding.
- Generalises the fixed Fibonacci generator:
  - configurable order, 2 to 4 (Fibonacci, tribonacci, tetranacci)
  - wrap or saturate overflow
  - optional bounded term count
  - stall control
- Sits at the synchronous/asynchronous boundary as a test-pattern and data source for downstream async pipelines.

Parameters:
- ENC, "TP", link encoding: "TP" two-phase (transition) or "FP" four-phase (return-to-zero).
- WIDTH, 32, term width in bits (min 4).
- ORDER, 2, number of previous terms summed (2..4).
- SAT, 0, overflow mode: 0 wraps modulo 2^WIDTH; 1 clamps to all-ones.
- COUNT, 0, number of terms emitted per run; 0 means unbounded.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run from the seed state
- next  in  1  level; permits the next term after the current handshake completes
- out_req  out  1  link request
- out_data  out  WIDTH  link data, bundled with out_req
- out_ack  in  1  link acknowledge (synchronous to clk unless SYNC_ACK_EN)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset (synchronous, active-high): all outputs 0.
  - History registers h[0..ORDER-1] = 0, except the newest h[ORDER-1] = 1.
  - Term counter = 0; state = IDLE.
  - rst mid-handshake forces out_req = 0 on the next edge. The TP receiver must be reset alongside.
- Sequence: term 0 = 0.
  - ORDER=2: 0,1,1,2,3,5,8,…
  - ORDER=3: 0,0,1,1,2,4,7,13,…
  - Each new term = sum of h[0..ORDER-1], computed at WIDTH+2 bits. History shifts by one each term.
- Overflow:
  - The sum is compared against 2^WIDTH-1.
  - SAT=0: truncate to WIDTH bits; ovf sets on the first truncation.
  - SAT=1: term = all-ones and ovf sets. The clamped value enters the history, so later terms stay all-ones.
  - ovf is cleared only by rst or by a start that is accepted.
- States: IDLE, SETUP, REQ, WAIT_ACK, RTZ (FP only), WAIT_RTZ (FP only), HOLD, DONE.
- IDLE:
  - start → SETUP, with history reseeded, counter cleared and ovf cleared.
  - Other inputs are ignored.
- SETUP: out_data is loaded with the current term. out_req is unchanged this cycle, so data leads req by at least one clock.
- REQ:
  - TP: out_req toggles.
  - FP: out_req = 1.
  - Next state is WAIT_ACK.
- WAIT_ACK:
  - TP: complete when ack equals out_req.
  - FP: complete when ack = 1, then → RTZ.
- RTZ: out_req = 0 → WAIT_RTZ.
- WAIT_RTZ: ack = 0 completes the handshake.
- Handshake complete (counter increments and history advances in the same cycle):
  - If COUNT≠0 and counter reaches COUNT → DONE.
  - Otherwise, next = 1 → SETUP; next = 0 → HOLD.
- HOLD: waits for next = 1, then → SETUP. out_data is held stable.
- DONE: done = 1. start → SETUP with the same reseed as from IDLE.
- Other start handling:
  - start in any busy state is ignored.
  - start and rst together: rst wins.
- Throughput (ack returns the cycle after req):
  - TP: one term per 3 clocks.
  - FP: one term per 5 clocks.
- Data contract: out_data never changes while a handshake is open, i.e. from the REQ edge until completion.

Optional Feature:
- Macro KFIB_SYNC_ACK_EN.
- Defined: out_ack passes through a 2-flop synchronizer (reset to 0) before any use. This adds 2 cycles to ack latency, and out_ack may be fully asynchronous.
- Undefined: out_ack is used directly and must be synchronous to clk.

Test Plan:
- ORDER=2, ENC="FP", WIDTH=32, responder acks 1 cycle after each req edge, next=1, start pulse → out_data sequence 0,1,1,2,3,5,8,13 at successive req rises, with 5 clocks between req rises.
- ORDER=3, ENC="TP" → data 0,0,1,1,2,4,7,13,24. out_req toggles once per term, with 3 clocks between toggles.
- WIDTH=8, SAT=0 → term 13 = 233, ovf=0; term 14 = 121 (377 mod 256), ovf=1 and stays set. A second start clears ovf and term 0 = 0.
- WIDTH=8, SAT=1 → term 14 = 255, ovf=1; terms 15 and 16 = 255.
- COUNT=5, next toggled low after term 2 for 10 cycles:
  - stall in HOLD with out_data = 1 stable and no req edge during the stall;
  - resume to terms 3 and 4, then done=1, busy=0;
  - start while busy mid-run is ignored.
- rst asserted in WAIT_ACK (FP) → next edge: out_req=0, busy=0, state IDLE. A subsequent start emits term 0 = 0.

Source files
------------

// File: rtl/kfib_src_if.sv
// Bundled-data req/ack link carrying one WIDTH-bit term per handshake.
interface kfib_src_if #(parameter int WIDTH = 32);
  logic             req;
  logic [WIDTH-1:0] data;
  logic             ack;

  modport master (output req, output data, input ack);
  modport slave  (input req, input data, output ack);
endinterface

// File: rtl/kfib_src.sv
// k-order Fibonacci source driving a two-phase or four-phase bundled-data link.
// Optional KFIB_SYNC_ACK_EN: route ack through a 2-flop synchronizer before use.
//
// state    | meaning
// IDLE     | after reset, waiting for start
// SETUP    | load out_data with the current term
// REQ      | raise (FP) or toggle (TP) out_req
// WAIT_ACK | wait for ack to match req (TP) or rise (FP)
// RTZ      | FP only: drop out_req
// WAIT_RTZ | FP only: wait for ack to fall
// HOLD     | stalled until next is high
// DONE     | COUNT terms emitted, waiting for start
module kfib_src #(
  parameter     ENC   = "TP",
  parameter int WIDTH = 32,
  parameter int ORDER = 2,
  parameter int SAT   = 0,
  parameter int COUNT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        next,
  kfib_src_if.master  link,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  localparam bit FP = (ENC == "FP");
  localparam logic [ORDER*WIDTH-1:0] SEED = (ORDER*WIDTH)'(1) << ((ORDER-1)*WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, WAIT_ACK, RTZ, WAIT_RTZ, HOLD, DONE} state_t;

  state_t                        state, state_nxt;
  logic [ORDER-1:0][WIDTH-1:0]   h;
  logic [ORDER-1:0]              hf;
  logic [31:0]                   cnt;
  logic                          req_q;
  logic [WIDTH-1:0]              data_q;
  logic                          ack;
  logic [WIDTH+1:0]              sum;
  logic                          sum_ovf;
  logic [WIDTH-1:0]              new_term;
  logic                          hs_done;
  logic                          last;
  logic                          accept;

`ifdef KFIB_SYNC_ACK_EN
  logic [1:0] ack_sync;
  always_ff @(posedge clk) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[0], link.ack};
  end
  assign ack = ack_sync[1];
`else
  assign ack = link.ack;
`endif

  always_comb begin
    sum = '0;
    for (int i = 0; i < ORDER; i++) sum = sum + (WIDTH+2)'(h[i]);
  end

  assign sum_ovf  = sum > (WIDTH+2)'({WIDTH{1'b1}});
  assign new_term = (sum_ovf && SAT != 0) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  assign hs_done = (state == WAIT_ACK && !FP && ack == req_q) ||
                   (state == WAIT_RTZ && !ack);
  assign last    = (COUNT != 0) && (cnt + 32'd1 == 32'(COUNT));
  assign accept  = start && (state == IDLE || state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = SETUP;
      SETUP:      state_nxt = REQ;
      REQ:        state_nxt = WAIT_ACK;
      WAIT_ACK:   if (FP && ack) state_nxt = RTZ;
      RTZ:        state_nxt = WAIT_RTZ;
      HOLD:       if (next) state_nxt = SETUP;
      default:    state_nxt = state;
    endcase
    if (hs_done) state_nxt = last ? DONE : (next ? SETUP : HOLD);
  end

  // Each history entry carries a truncation flag so ovf rises with the term that was truncated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      data_q <= '0;
      ovf    <= 1'b0;
      cnt    <= '0;
      h      <= SEED;
      hf     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        h   <= SEED;
        hf  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (state == SETUP) begin
        data_q <= h[0];
        ovf    <= ovf | hf[0];
      end
      if (state == REQ) req_q <= FP ? 1'b1 : ~req_q;
      if (state == RTZ) req_q <= 1'b0;
      if (hs_done) begin
        cnt <= cnt + 32'd1;
        h   <= {new_term, h[ORDER-1:1]};
        hf  <= {sum_ovf, hf[ORDER-1:1]};
      end
    end
  end

  assign link.req  = req_q;
  assign link.data = data_q;
  assign busy      = !(state == IDLE || state == DONE);
  assign done      = (state == DONE);

endmodule
